biriq_branch_resolve: RTL and testbench

BIRIQ_BRANCH_RESOLVE -- requirements
Module: biriq_branch_resolve

---
 rtl/biriq_pkg.sv | 31 +++
 rtl/biriq_branch_cond.sv | 41 ++++
 rtl/biriq_branch_resolve.sv | 186 ++++++++++++++++++
 tb/tb_biriq_branch_resolve.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biriq_pkg.sv
// ---------------------------------------------------------------------------
// biriq_pkg
// Shared definitions for the branch-resolution block:
//   - RISC-V branch funct3 condition encodings
//   - resolve FSM state type br_state_t
//   - default ROB tag width
//   - helper that tells whether a funct3 value is a real conditional branch
// ---------------------------------------------------------------------------
package biriq_pkg;

    localparam int ROB_ID_W_DEFAULT = 6;

    localparam logic [2:0] BCOND_EQ  = 3'b000;
    localparam logic [2:0] BCOND_NE  = 3'b001;
    localparam logic [2:0] BCOND_LT  = 3'b100;
    localparam logic [2:0] BCOND_GE  = 3'b101;
    localparam logic [2:0] BCOND_LTU = 3'b110;
    localparam logic [2:0] BCOND_GEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } br_state_t;

    // 010/011 are not branch encodings; everything else is a conditional branch.
    function automatic logic bcond_is_cond(input logic [2:0] bcond);
        return (bcond != 3'b010) && (bcond != 3'b011);
    endfunction

endpackage

// File: rtl/biriq_branch_cond.sv
// ---------------------------------------------------------------------------
// biriq_branch_cond
// Purely combinational taken decode for a resolved branch.
// Ports:
//   bcond_i  - funct3 branch condition
//   jump_i   - unconditional jump, forces taken
//   mts_i    - rs1 > rs2 (signed)
//   mtu_i    - rs1 > rs2 (unsigned)
//   eq_i     - rs1 == rs2
//   taken_o  - resolved direction
// ---------------------------------------------------------------------------
module biriq_branch_cond
    import biriq_pkg::*;
(
    input  logic [2:0] bcond_i,
    input  logic       jump_i,
    input  logic       mts_i,
    input  logic       mtu_i,
    input  logic       eq_i,
    output logic       taken_o
);

    logic cond_taken;

    // LT/LTU are "not greater and not equal"; GE/GEU are their complements.
    always_comb begin
        cond_taken = 1'b0;
        case (bcond_i)
            BCOND_EQ:  cond_taken = eq_i;
            BCOND_NE:  cond_taken = !eq_i;
            BCOND_LT:  cond_taken = !(mts_i | eq_i);
            BCOND_GE:  cond_taken = mts_i | eq_i;
            BCOND_LTU: cond_taken = !(mtu_i | eq_i);
            BCOND_GEU: cond_taken = mtu_i | eq_i;
            default:   cond_taken = 1'b0;
        endcase
    end

    assign taken_o = jump_i | cond_taken;

endmodule

// File: rtl/biriq_branch_resolve.sv
// ---------------------------------------------------------------------------
// biriq_branch_resolve
// Resolves branch ops against their prediction, writes the result back to
// the ROB one cycle after acceptance and requests a frontend redirect on a
// mispredict. After a redirect is taken, younger ops are discarded until the
// ROB flushes.
//
// Optional feature macro: BIRIQ_BRANCH_BP_UPDATE_EN
//   defined   - bp_* carries a predictor update alongside each branch writeback
//   undefined - bp_* outputs are tied to 0
//
// Ports:
//   cpu_clock_i / cpu_reset_i         clock, synchronous active-high reset
//   valid_i / ready_o                 op handshake
//   rob_id_i, pc_i, target_i          op tag, branch PC, computed taken target
//   bcond_i, jump_i, mts_i/mtu_i/eq_i condition and compare flags
//   pred_taken_i, pred_target_i       prediction to verify
//   flush_i                           ROB global flush
//   wb_valid_o/wb_rob_id_o/wb_mispredict_o   completion
//   redirect_valid_o/redirect_pc_o/redirect_ready_i  frontend redirect
//   bp_valid_o/bp_pc_o/bp_target_o/bp_taken_o        predictor update
// ---------------------------------------------------------------------------
module biriq_branch_resolve #(
    parameter int ROB_ID_W = biriq_pkg::ROB_ID_W_DEFAULT
) (
    input  logic                cpu_clock_i,
    input  logic                cpu_reset_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [ROB_ID_W-1:0] rob_id_i,
    input  logic [31:0]         pc_i,
    input  logic [31:0]         target_i,
    input  logic [2:0]          bcond_i,
    input  logic                jump_i,
    input  logic                mts_i,
    input  logic                mtu_i,
    input  logic                eq_i,
    input  logic                pred_taken_i,
    input  logic [31:0]         pred_target_i,
    input  logic                flush_i,
    output logic                wb_valid_o,
    output logic [ROB_ID_W-1:0] wb_rob_id_o,
    output logic                wb_mispredict_o,
    output logic                redirect_valid_o,
    output logic [31:0]         redirect_pc_o,
    input  logic                redirect_ready_i,
    output logic                bp_valid_o,
    output logic [31:0]         bp_pc_o,
    output logic [31:0]         bp_target_o,
    output logic                bp_taken_o
);

    import biriq_pkg::*;

    logic        taken;
    logic        accept;
    logic        mispredict;
    logic [31:0] correct_pc;

    br_state_t           state_q,         state_d;
    logic                wb_valid_q,      wb_valid_d;
    logic [ROB_ID_W-1:0] wb_rob_id_q,     wb_rob_id_d;
    logic                wb_mispredict_q, wb_mispredict_d;
    logic [31:0]         redirect_pc_q,   redirect_pc_d;

    biriq_branch_cond u_cond (
        .bcond_i (bcond_i),
        .jump_i  (jump_i),
        .mts_i   (mts_i),
        .mtu_i   (mtu_i),
        .eq_i    (eq_i),
        .taken_o (taken)
    );

    // Handshake and redirect request are pure state decodes, so they are
    // glitch-free and valid in the first cycle after reset.
    assign ready_o          = (state_q != ST_REDIRECT);
    assign redirect_valid_o = (state_q == ST_REDIRECT);
    assign accept           = valid_i && ready_o;

    assign mispredict = (taken != pred_taken_i) || (taken && (target_i != pred_target_i));
    assign correct_pc = taken ? target_i : (pc_i + 32'd4);

    always_comb begin
        state_d         = state_q;
        wb_valid_d      = 1'b0;
        wb_rob_id_d     = wb_rob_id_q;
        wb_mispredict_d = wb_mispredict_q;
        redirect_pc_d   = redirect_pc_q;

        if (flush_i) begin
            // Flush squashes a same-cycle op and any pending redirect.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        wb_valid_d      = 1'b1;
                        wb_rob_id_d     = rob_id_i;
                        wb_mispredict_d = mispredict;
                        if (mispredict) begin
                            redirect_pc_d = correct_pc;
                            state_d       = ST_REDIRECT;
                        end
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready_i) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Ops are accepted but dropped: they are on the wrong path.
                    state_d = ST_DRAIN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            state_q         <= ST_IDLE;
            wb_valid_q      <= 1'b0;
            wb_rob_id_q     <= '0;
            wb_mispredict_q <= 1'b0;
            redirect_pc_q   <= '0;
        end else begin
            state_q         <= state_d;
            wb_valid_q      <= wb_valid_d;
            wb_rob_id_q     <= wb_rob_id_d;
            wb_mispredict_q <= wb_mispredict_d;
            redirect_pc_q   <= redirect_pc_d;
        end
    end

    assign wb_valid_o      = wb_valid_q;
    assign wb_rob_id_o     = wb_rob_id_q;
    assign wb_mispredict_o = wb_mispredict_q;
    assign redirect_pc_o   = redirect_pc_q;

`ifdef BIRIQ_BRANCH_BP_UPDATE_EN
    logic        bp_valid_q,  bp_valid_d;
    logic [31:0] bp_pc_q,     bp_pc_d;
    logic [31:0] bp_target_q, bp_target_d;
    logic        bp_taken_q,  bp_taken_d;

    // Update rides on the same edge as the writeback it belongs to.
    always_comb begin
        bp_valid_d  = wb_valid_d && (jump_i || bcond_is_cond(bcond_i));
        bp_pc_d     = bp_pc_q;
        bp_target_d = bp_target_q;
        bp_taken_d  = bp_taken_q;
        if (bp_valid_d) begin
            bp_pc_d     = pc_i;
            bp_target_d = target_i;
            bp_taken_d  = taken;
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            bp_valid_q  <= 1'b0;
            bp_pc_q     <= '0;
            bp_target_q <= '0;
            bp_taken_q  <= 1'b0;
        end else begin
            bp_valid_q  <= bp_valid_d;
            bp_pc_q     <= bp_pc_d;
            bp_target_q <= bp_target_d;
            bp_taken_q  <= bp_taken_d;
        end
    end

    assign bp_valid_o  = bp_valid_q;
    assign bp_pc_o     = bp_pc_q;
    assign bp_target_o = bp_target_q;
    assign bp_taken_o  = bp_taken_q;
`else
    assign bp_valid_o  = 1'b0;
    assign bp_pc_o     = '0;
    assign bp_target_o = '0;
    assign bp_taken_o  = 1'b0;
`endif

endmodule

// File: tb/tb_biriq_branch_resolve.sv
// ---------------------------------------------------------------------------
// tb_biriq_branch_resolve
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model that derives branch outcomes from the compared operand
// values and tracks the redirect/drain protocol as simple flags.
// ---------------------------------------------------------------------------
module tb_biriq_branch_resolve;

    localparam int RW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic          ready_o;
    logic [RW-1:0] rob_id_i;
    logic [31:0]   pc_i;
    logic [31:0]   target_i;
    logic [2:0]    bcond_i;
    logic          jump_i;
    logic          mts_i, mtu_i, eq_i;
    logic          pred_taken_i;
    logic [31:0]   pred_target_i;
    logic          flush_i;
    logic          wb_valid_o;
    logic [RW-1:0] wb_rob_id_o;
    logic          wb_mispredict_o;
    logic          redirect_valid_o;
    logic [31:0]   redirect_pc_o;
    logic          redirect_ready_i;
    logic          bp_valid_o;
    logic [31:0]   bp_pc_o, bp_target_o;
    logic          bp_taken_o;

    always #5 clk = ~clk;

    biriq_branch_resolve #(.ROB_ID_W(RW)) dut (
        .cpu_clock_i      (clk),
        .cpu_reset_i      (rst),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .rob_id_i         (rob_id_i),
        .pc_i             (pc_i),
        .target_i         (target_i),
        .bcond_i          (bcond_i),
        .jump_i           (jump_i),
        .mts_i            (mts_i),
        .mtu_i            (mtu_i),
        .eq_i             (eq_i),
        .pred_taken_i     (pred_taken_i),
        .pred_target_i    (pred_target_i),
        .flush_i          (flush_i),
        .wb_valid_o       (wb_valid_o),
        .wb_rob_id_o      (wb_rob_id_o),
        .wb_mispredict_o  (wb_mispredict_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .bp_valid_o       (bp_valid_o),
        .bp_pc_o          (bp_pc_o),
        .bp_target_o      (bp_target_o),
        .bp_taken_o       (bp_taken_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Operands behind the compare flags; the model works from these.
    logic [31:0] op_a, op_b;

    // Model state: a redirect is outstanding / wrong-path ops are being dropped.
    bit          m_blocked;
    bit          m_dropping;
    logic [31:0] m_rpc;
    bit          m_wb;
    logic [RW-1:0] m_wbid;
    bit          m_wbmp;
    bit          m_bp;
    logic [31:0] m_bp_pc, m_bp_tgt;
    bit          m_bp_taken;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cmp(input logic [31:0] a, input logic [31:0] b);
        op_a  = a;
        op_b  = b;
        eq_i  = (a == b);
        mts_i = ($signed(a) > $signed(b));
        mtu_i = (a > b);
    endtask

    // RISC-V branch semantics on the actual operands.
    function automatic bit ref_taken(input logic [2:0] f, input bit j,
                                     input logic [31:0] a, input logic [31:0] b);
        if (j) return 1'b1;
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle_inputs();
        valid_i = 0; rob_id_i = '0; pc_i = 0; target_i = 0; bcond_i = 3'd2;
        jump_i = 0; pred_taken_i = 0; pred_target_i = 0; flush_i = 0;
        redirect_ready_i = 0; rst = 0;
        set_cmp(32'd1, 32'd2);
    endtask

    // One clock: check current handshake outputs, advance model, clock,
    // then check the registered results. Called at a negedge.
    task automatic tick();
        bit acc, tk, mp;
        logic [31:0] cpc;
        chk("ready", 32'(ready_o), 32'(!m_blocked));
        chk("redir_valid", 32'(redirect_valid_o), 32'(m_blocked));
        if (m_blocked) chk("redir_pc", redirect_pc_o, m_rpc);

        acc = valid_i && !m_blocked;
        tk  = ref_taken(bcond_i, jump_i, op_a, op_b);
        mp  = (tk != pred_taken_i) || (tk && target_i != pred_target_i);
        cpc = tk ? target_i : pc_i + 32'd4;

        m_wb = 0;
        m_bp = 0;
        if (rst) begin
            m_blocked = 0; m_dropping = 0;
        end else if (flush_i) begin
            m_blocked = 0; m_dropping = 0;
        end else if (m_blocked) begin
            if (redirect_ready_i) begin
                m_blocked = 0; m_dropping = 1;
            end
        end else if (acc && !m_dropping) begin
            m_wb = 1; m_wbid = rob_id_i; m_wbmp = mp;
            m_bp = jump_i || (bcond_i != 3'd2 && bcond_i != 3'd3);
            m_bp_pc = pc_i; m_bp_tgt = target_i; m_bp_taken = tk;
            if (mp) begin
                m_blocked = 1; m_rpc = cpc;
            end
        end

        @(posedge clk);
        @(negedge clk);
        chk("wb_valid", 32'(wb_valid_o), 32'(m_wb));
        if (m_wb) begin
            chk("wb_rob_id", 32'(wb_rob_id_o), 32'(m_wbid));
            chk("wb_mispredict", 32'(wb_mispredict_o), 32'(m_wbmp));
        end
`ifdef BIRIQ_BRANCH_BP_UPDATE_EN
        chk("bp_valid", 32'(bp_valid_o), 32'(m_bp));
        if (m_bp) begin
            chk("bp_pc", bp_pc_o, m_bp_pc);
            chk("bp_target", bp_target_o, m_bp_tgt);
            chk("bp_taken", 32'(bp_taken_o), 32'(m_bp_taken));
        end
`else
        chk("bp_valid", 32'(bp_valid_o), 32'd0);
        chk("bp_pc", bp_pc_o | bp_target_o | 32'(bp_taken_o), 32'd0);
`endif
    endtask

    initial begin
        idle_inputs();
        m_blocked = 0; m_dropping = 0; m_rpc = 0; m_wbid = '0; m_wbmp = 0;
        m_bp_pc = 0; m_bp_tgt = 0; m_bp_taken = 0;

        // Reset with an op presented: nothing may come out.
        rst = 1; valid_i = 1; rob_id_i = 6'd9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_redir_valid", 32'(redirect_valid_o), 32'd0);
        chk("rst_bp_valid", 32'(bp_valid_o), 32'd0);
        chk("rst_wb_rob_id", 32'(wb_rob_id_o), 32'd0);
        chk("rst_wb_misp", 32'(wb_mispredict_o), 32'd0);
        chk("rst_redir_pc", redirect_pc_o, 32'd0);
        idle_inputs();
        chk("rst_ready_after", 32'(ready_o), 32'd1);

        // S1: BLT taken (a<b signed), correctly predicted.
        valid_i = 1; rob_id_i = 6'd1; bcond_i = 3'b100; set_cmp(32'hFFFF_FFF0, 32'd5);
        pc_i = 32'h80; target_i = 32'h1000; pred_taken_i = 1; pred_target_i = 32'h1000;
        tick();
        chk("s1_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("s1_misp", 32'(wb_mispredict_o), 32'd0);
        chk("s1_no_redirect", 32'(redirect_valid_o), 32'd0);

        // Back-to-back acceptance in IDLE.
        rob_id_i = 6'd2; bcond_i = 3'b110; set_cmp(32'd3, 32'd3);
        pred_taken_i = 0;
        tick();
        chk("b2b_ready", 32'(ready_o), 32'd1);

        // S2: BEQ taken but predicted not-taken; redirect held 3 cycles.
        rob_id_i = 6'd3; bcond_i = 3'b000; set_cmp(32'd7, 32'd7);
        pc_i = 32'h100; target_i = 32'h2000; pred_taken_i = 0; pred_target_i = 0;
        tick();
        chk("s2_misp", 32'(wb_mispredict_o), 32'd1);
        rob_id_i = 6'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s2_hold_valid", 32'(redirect_valid_o), 32'd1);
            chk("s2_hold_pc", redirect_pc_o, 32'h2000);
            chk("s2_hold_ready", 32'(ready_o), 32'd0);
        end
        valid_i = 0; redirect_ready_i = 1;
        tick();
        chk("s2_redir_done", 32'(redirect_valid_o), 32'd0);
        redirect_ready_i = 0; valid_i = 1;
        for (int i = 0; i < 2; i++) begin
            rob_id_i = 6'(10 + i);
            tick();
            chk("drain_no_wb", 32'(wb_valid_o), 32'd0);
        end
        flush_i = 1;
        tick();
        flush_i = 0; rob_id_i = 6'd12; bcond_i = 3'b001; set_cmp(32'd1, 32'd1);
        pred_taken_i = 0;
        tick();
        chk("post_flush_wb", 32'(wb_valid_o), 32'd1);
        chk("post_flush_id", 32'(wb_rob_id_o), 32'd12);

        // S3: jump with wrong predicted target; flush+redirect_ready together.
        rob_id_i = 6'd13; jump_i = 1; bcond_i = 3'b011; pred_taken_i = 1;
        pred_target_i = 32'h40; target_i = 32'h44;
        tick();
        chk("s3_misp", 32'(wb_mispredict_o), 32'd1);
        chk("s3_redir_pc", redirect_pc_o, 32'h44);
        jump_i = 0; valid_i = 0; flush_i = 1; redirect_ready_i = 1;
        tick();
        chk("s3_flush_redir", 32'(redirect_valid_o), 32'd0);
        chk("s3_flush_ready", 32'(ready_o), 32'd1);
        flush_i = 0; redirect_ready_i = 0;

        // S4: BNE not taken at top of memory, predicted taken: PC wraps.
        valid_i = 1; rob_id_i = 6'd14; pc_i = 32'hFFFF_FFFC; bcond_i = 3'b001;
        set_cmp(32'd9, 32'd9); pred_taken_i = 1; target_i = 32'h300; pred_target_i = 32'h300;
        tick();
        chk("s4_redir_pc", redirect_pc_o, 32'h0);
        valid_i = 0; rst = 1;
        tick();
        chk("s4_rst_redir", 32'(redirect_valid_o), 32'd0);
        rst = 0;

        // Flush kills an op accepted in the same cycle.
        valid_i = 1; rob_id_i = 6'd15; flush_i = 1; bcond_i = 3'b101; set_cmp(32'd1, 32'd0);
        tick();
        chk("flush_kill", 32'(wb_valid_o), 32'd0);
        flush_i = 0;

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, b;
            valid_i  = ($urandom_range(0, 3) != 0);
            rob_id_i = 6'($urandom);
            pc_i     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            target_i = $urandom & 32'hFFFF_FFFC;
            bcond_i  = 3'($urandom);
            jump_i   = ($urandom_range(0, 7) == 0);
            a = $urandom;
            case ($urandom_range(0, 2))
                0: b = a;
                1: b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = $urandom;
            endcase
            set_cmp(a, b);
            pred_taken_i  = ($urandom_range(0, 1) == 0) ? ref_taken(bcond_i, jump_i, a, b)
                                                        : 1'($urandom);
            pred_target_i = ($urandom_range(0, 3) != 0) ? target_i : ($urandom & 32'hFFFF_FFFC);
            flush_i          = ($urandom_range(0, 15) == 0);
            redirect_ready_i = ($urandom_range(0, 2) == 0);
            rst              = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
